// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word reads to the read cache and buffers
// returned words in a small FIFO handed to decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        JMP_DO,
  input  logic [31:0] JMP_ADDR,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_RDEN,
  input  logic [31:0] MEM_OADDR,
  input  logic [31:0] MEM_DOUT,
  input  logic        MEM_VALID,
  input  logic        MEM_LOADING,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  output logic        INST_VALID,
  input  logic        INST_READY
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     inst_mem_q [FIFO_DEPTH];
  logic [31:0]     addr_mem_q [FIFO_DEPTH];

  logic [CntW:0] credit_used;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;

  // Credit covers the word still in flight so a return always has a free slot.
  assign credit_used = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign full        = (count_q == CntW'(FIFO_DEPTH));

  assign MEM_ADDR   = pc_q;
  assign MEM_RDEN   = RST & ~JMP_DO & (credit_used < (CntW + 1)'(FIFO_DEPTH));
  assign accept     = MEM_RDEN & ~MEM_LOADING;
  assign push       = MEM_VALID & ~JMP_DO & ~full;
  assign pop        = INST_VALID & INST_READY & ~JMP_DO;

  assign INST_VALID = (count_q != '0);
  assign INST       = inst_mem_q[rd_ptr_q];
  assign INST_PC    = addr_mem_q[rd_ptr_q];

  always_comb begin
    pc_d       = pc_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (JMP_DO) begin
      pc_d     = {JMP_ADDR[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        pc_d       = pc_q + 32'd4;
        inflight_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        inst_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        inst_mem_q[wr_ptr_q] <= MEM_DOUT;
        addr_mem_q[wr_ptr_q] <= MEM_OADDR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked every cycle against a
// queue-based model of the fetch pipeline and a 1-cycle-latency cache model.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0100;
  localparam int          Depth   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        jmp_do;
  logic [31:0] jmp_addr;
  logic [31:0] mem_addr;
  logic        mem_rden;
  logic [31:0] mem_oaddr;
  logic [31:0] mem_dout;
  logic        mem_valid;
  logic        mem_loading;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  fetch_unit #(
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(Depth)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .JMP_DO     (jmp_do),
    .JMP_ADDR   (jmp_addr),
    .MEM_ADDR   (mem_addr),
    .MEM_RDEN   (mem_rden),
    .MEM_OADDR  (mem_oaddr),
    .MEM_DOUT   (mem_dout),
    .MEM_VALID  (mem_valid),
    .MEM_LOADING(mem_loading),
    .INST       (inst),
    .INST_PC    (inst_pc),
    .INST_VALID (inst_valid),
    .INST_READY (inst_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Scenario controls
  bit          rst_v = 1'b1;
  bit          jmp_v = 1'b0;
  bit          jmp_pulse = 1'b0;
  bit          jmp_on8 = 1'b0;
  bit          seen8 = 1'b0;
  logic [31:0] jaddr_v = '0;
  bit          ready_v = 1'b1;
  int          miss_left = 0;

  // Cache model: answers the DUT's accepted request one cycle later
  bit          c_valid = 1'b0;
  logic [31:0] c_addr = '0;

  // Reference model of the fetch pipeline
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc = ResetPc;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = '0;
  bit          m_just_rst = 1'b1;

  task automatic step();
    bit          jmp_now;
    bit          load_now;
    bit          exp_rden;
    bit          c_req_n;
    logic [31:0] c_addr_n;
    ent_t        e;
    @(negedge clk);
    if (jmp_on8 && c_valid && c_addr == 32'h8) begin
      jmp_pulse = 1'b1;
      jaddr_v   = 32'h2003;
      jmp_on8   = 1'b0;
      seen8     = 1'b1;
    end
    jmp_now     = jmp_v | jmp_pulse;
    load_now    = (miss_left > 0);
    rst         = rst_v;
    jmp_do      = jmp_now;
    jmp_addr    = jaddr_v;
    inst_ready  = ready_v;
    mem_loading = load_now;
    mem_valid   = c_valid;
    mem_oaddr   = c_valid ? c_addr : $urandom;
    mem_dout    = c_valid ? mem_word(c_addr) : $urandom;
    #1;
    exp_rden = rst_v && !jmp_now && ((m_q.size() + int'(m_pend)) < Depth);
    check_eq("mem_addr", mem_addr, m_pc);
    check_eq("mem_rden", {31'b0, mem_rden}, {31'b0, exp_rden});
    check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      check_eq("inst_pc", inst_pc, m_q[0].pc);
      check_eq("inst", inst, m_q[0].word);
    end else if (m_just_rst) begin
      check_eq("inst_after_rst", inst, 32'h0);
      check_eq("inst_pc_after_rst", inst_pc, 32'h0);
    end
    c_req_n  = mem_rden && !mem_loading;
    c_addr_n = mem_addr;
    @(posedge clk);
    // Model update for the edge just taken
    m_just_rst = 1'b0;
    if (!rst_v) begin
      m_pc       = ResetPc;
      m_q.delete();
      m_pend     = 1'b0;
      m_just_rst = 1'b1;
    end else if (jmp_now) begin
      m_pc   = {jaddr_v[31:2], 2'b00};
      m_q.delete();
      m_pend = 1'b0;
    end else begin
      if (m_q.size() != 0 && ready_v) void'(m_q.pop_front());
      if (m_pend) begin
        e.pc   = m_pend_pc;
        e.word = mem_word(m_pend_pc);
        m_q.push_back(e);
      end
      m_pend    = exp_rden && !load_now;
      m_pend_pc = m_pc;
      if (m_pend) m_pc = m_pc + 32'd4;
    end
    c_valid   = c_req_n;
    c_addr    = c_addr_n;
    jmp_pulse = 1'b0;
    if (miss_left > 0) miss_left--;
  endtask

  task automatic jump_to(input logic [31:0] a);
    jmp_v   = 1'b1;
    jaddr_v = a;
    step();
    jmp_v   = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    jmp_do      = 1'b0;
    jmp_addr    = '0;
    inst_ready  = 1'b1;
    mem_loading = 1'b0;
    mem_valid   = 1'b0;
    mem_oaddr   = '0;
    mem_dout    = '0;
    repeat (2) @(posedge clk);

    // Reset held one more cycle, then straight-line fetch from ResetPc
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    repeat (20) step();

    // Long miss at 0x1000
    jump_to(32'h1000);
    miss_left = 40;
    repeat (50) step();

    // Backpressure from 0x0 until the FIFO fills, then drain
    ready_v = 1'b0;
    jump_to(32'h0);
    repeat (10) step();
    ready_v = 1'b1;
    repeat (10) step();

    // Redirect to 0x2003 in the cycle the word for 0x8 returns
    jump_to(32'h0);
    jmp_on8 = 1'b1;
    repeat (12) step();
    check_eq("jmp_on_ret8_fired", {31'b0, seen8}, 32'h1);
    jmp_on8 = 1'b0;

    // Address wrap with READY toggling every cycle
    jump_to(32'hFFFF_FFF8);
    repeat (16) begin
      ready_v = !ready_v;
      step();
    end
    ready_v = 1'b1;

    // Reset while full and redirecting
    ready_v = 1'b0;
    jump_to(32'h40);
    repeat (8) step();
    rst_v   = 1'b0;
    jmp_v   = 1'b1;
    jaddr_v = $urandom;
    step();
    rst_v   = 1'b1;
    jmp_v   = 1'b0;
    ready_v = 1'b1;
    repeat (10) step();

    // Randomized traffic
    repeat (400) begin
      rst_v   = ($urandom_range(0, 60) != 0);
      jmp_v   = ($urandom_range(0, 9) == 0);
      jaddr_v = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
      ready_v = ($urandom_range(0, 2) != 0);
      if (miss_left == 0 && $urandom_range(0, 15) == 0) miss_left = $urandom_range(1, 6);
      step();
    end
    rst_v = 1'b1;
    jmp_v = 1'b0;
    ready_v = 1'b1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
